// File: rtl/ddfs_mixer_mc.sv
// Multi-channel DDFS mixer: steps N_CH phase accumulators through a shared 3-stage pipeline per sample tick.
// Define DDFS_SINE_LUT_EN to build the sine ROM (wave=3); otherwise wave=3 behaves as triangle.
module ddfs_mixer_mc #(
  parameter int N_CH      = 4,
  parameter int PHASE_W   = 30,
  parameter int DATA_W    = 16,
  parameter int AMP_W     = 8,
  parameter int LUT_AW    = 10,
  parameter     SINE_FILE = "sin_lut.txt"
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic                      wr,
  input  logic [$clog2(N_CH)+1:0]   addr,
  input  logic [31:0]               wr_data,
  output logic [31:0]               rd_data,
  output logic [DATA_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      busy
);
  localparam int CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int ACC_W  = DATA_W + $clog2(N_CH) + 1;
  localparam int CTRL_W = AMP_W + 3;

  localparam logic [DATA_W-1:0] POS_FS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_FS = {1'b1, {(DATA_W-2){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] MIN_FS = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic [CW-1:0] ch;
  logic [1:0]  drain_cnt;
  logic [7:0]  ovr;

  logic [PHASE_W-1:0] fcw   [N_CH];
  logic [PHASE_W-1:0] pcw   [N_CH];
  logic [PHASE_W-1:0] phase [N_CH];
  logic [CTRL_W-1:0]  ctrl  [N_CH];

  logic [CW-1:0] sel_ch;
  logic [1:0]    sel_reg;
  logic          addr_ok;
  logic          ovr_clr;
  logic          issue;

  assign sel_ch  = CW'(addr >> 2);
  assign sel_reg = addr[1:0];
  assign addr_ok = int'(sel_ch) < N_CH;
  assign ovr_clr = wr && addr_ok && (sel_ch == '0) && (sel_reg == 2'd3);
  assign issue   = (state == RUN);

  // Register file and phase accumulators; a ctrl write with enable=0 beats the accumulator step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        fcw[i]   <= '0;
        pcw[i]   <= '0;
        ctrl[i]  <= '0;
        phase[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (wr && addr_ok && int'(sel_ch) == i) begin
          case (sel_reg)
            2'd0:    fcw[i]  <= wr_data[PHASE_W-1:0];
            2'd1:    pcw[i]  <= wr_data[PHASE_W-1:0];
            2'd2:    ctrl[i] <= wr_data[CTRL_W-1:0];
            default: ;
          endcase
        end
        if (wr && addr_ok && int'(sel_ch) == i && sel_reg == 2'd2 && !wr_data[0])
          phase[i] <= '0;
        else if (issue && int'(ch) == i)
          phase[i] <= ctrl[i][0] ? phase[i] + fcw[i] : '0;
      end
    end
  end

  // Stage 1: offset phase and capture per-channel settings
  logic [PHASE_W-1:0] p;
  logic               s1_valid, s1_en;
  logic [1:0]         s1_wave;
  logic [AMP_W-1:0]   s1_amp;
  logic [DATA_W-1:0]  s1_ptop;
  // Stage 2: waveform value
  logic               s2_valid, s2_en;
  logic [AMP_W-1:0]   s2_amp;
  logic [DATA_W-1:0]  s2_w;
  logic [DATA_W-1:0]  w_calc;
  // Stage 3: scale and accumulate
  logic [DATA_W-1:0]             w3;
  logic signed [DATA_W+AMP_W:0]  prod;
  logic signed [DATA_W-1:0]      scaled;
  logic signed [ACC_W-1:0]       acc;
  logic [DATA_W-1:0]             sat_val;

  assign p = phase[ch] + pcw[ch];

  logic unused_bits;
  assign unused_bits = ^{wr_data, p};

  always_comb begin
    w_calc = '0;
    case (s1_wave)
      2'd0:    w_calc = s1_ptop[DATA_W-1] ? NEG_FS : POS_FS;
      2'd1:    w_calc = {~s1_ptop[DATA_W-1], s1_ptop[DATA_W-2:0]};
      default: w_calc = s1_ptop[DATA_W-1] ? POS_FS - {s1_ptop[DATA_W-2:0], 1'b0}
                                          : MIN_FS + {s1_ptop[DATA_W-2:0], 1'b0};
    endcase
  end

`ifdef DDFS_SINE_LUT_EN
  logic [LUT_AW-1:0] s1_addr;
  logic              s2_sine;
  logic [DATA_W-1:0] sine_rom [2**LUT_AW];
  logic [DATA_W-1:0] rom_q;

  function automatic logic [DATA_W-1:0] sine_entry(input int k);
    real x;
    x = (2.0 ** (DATA_W - 1) - 1.0) * $sin(2.0 * 3.141592653589793 * k / (2.0 ** LUT_AW));
    if (x >= 0.0)
      return DATA_W'($rtoi(x + 0.5));
    else
      return DATA_W'(-$rtoi(0.5 - x));
  endfunction

  initial begin
    for (int k = 0; k < 2**LUT_AW; k++)
      sine_rom[k] = sine_entry(k);
  end

  always_ff @(posedge clk) begin
    rom_q <= sine_rom[s1_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_addr <= '0;
      s2_sine <= 1'b0;
    end else begin
      s1_addr <= p[PHASE_W-1 -: LUT_AW];
      s2_sine <= (s1_wave == 2'd3);
    end
  end

  assign w3 = s2_sine ? rom_q : s2_w;
`else
  assign w3 = s2_w;
`endif

  assign prod   = $signed(w3) * $signed({1'b0, s2_amp});
  assign scaled = prod[DATA_W+AMP_W-1:AMP_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_en    <= 1'b0;
      s1_wave  <= '0;
      s1_amp   <= '0;
      s1_ptop  <= '0;
      s2_valid <= 1'b0;
      s2_en    <= 1'b0;
      s2_amp   <= '0;
      s2_w     <= '0;
      acc      <= '0;
    end else begin
      s1_valid <= issue;
      s1_en    <= ctrl[ch][0];
      s1_wave  <= ctrl[ch][2:1];
      s1_amp   <= ctrl[ch][CTRL_W-1:3];
      s1_ptop  <= p[PHASE_W-1 -: DATA_W];
      s2_valid <= s1_valid;
      s2_en    <= s1_en;
      s2_amp   <= s1_amp;
      s2_w     <= w_calc;
      if (state == IDLE && sample_tick)
        acc <= '0;
      else if (s2_valid && s2_en)
        acc <= acc + {{(ACC_W-DATA_W){scaled[DATA_W-1]}}, scaled};
    end
  end

  always_comb begin
    if (acc > ACC_MAX)      sat_val = POS_FS;
    else if (acc < ACC_MIN) sat_val = MIN_FS;
    else                    sat_val = acc[DATA_W-1:0];
  end

  // Frame sequencer; DRAIN lasts until the last issued channel has left stage 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ch         <= '0;
      drain_cnt  <= '0;
      ovr        <= '0;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (ovr_clr)
        ovr <= '0;
      else if (sample_tick && state != IDLE && ovr != 8'hFF)
        ovr <= ovr + 8'd1;
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RUN;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (int'(ch) == N_CH - 1) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 2'd2) state <= DONE;
          else                   drain_cnt <= drain_cnt + 2'd1;
        end
        DONE: begin
          dout       <= sat_val;
          dout_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr_ok) begin
      case (sel_reg)
        2'd0:    rd_data[PHASE_W-1:0] = fcw[sel_ch];
        2'd1:    rd_data[PHASE_W-1:0] = pcw[sel_ch];
        2'd2:    rd_data[CTRL_W-1:0]  = ctrl[sel_ch];
        default: if (sel_ch == '0) rd_data[8:0] = {busy, ovr};
      endcase
    end
  end

endmodule

// File: tb/tb_ddfs_mixer_mc.sv
// Self-checking bench for ddfs_mixer_mc: directed scenarios plus randomized channel settings
// compared against an arithmetic frame model.
module tb_ddfs_mixer_mc;
  localparam int N_CH    = 4;
  localparam int PHASE_W = 30;
  localparam int DATA_W  = 16;
  localparam int AMP_W   = 8;
  localparam int LUT_AW  = 10;
  localparam longint PMASK = (64'd1 << PHASE_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [15:0] dout;
  logic        dout_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_dout;

  longint m_fcw [N_CH];
  longint m_pcw [N_CH];
  longint m_phase [N_CH];
  int     m_en [N_CH];
  int     m_wave [N_CH];
  int     m_amp [N_CH];
  int     m_ovr;

  always #5 clk = ~clk;

  ddfs_mixer_mc #(
    .N_CH(N_CH), .PHASE_W(PHASE_W), .DATA_W(DATA_W), .AMP_W(AMP_W), .LUT_AW(LUT_AW),
    .SINE_FILE("sin_lut.txt")
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .wr(wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .dout(dout), .dout_valid(dout_valid), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N_CH; i++) begin
      m_fcw[i] = 0; m_pcw[i] = 0; m_phase[i] = 0;
      m_en[i] = 0; m_wave[i] = 0; m_amp[i] = 0;
    end
    m_ovr = 0;
  endtask

  function automatic int wave_val(int wave, longint p);
    longint ptop = p >> (PHASE_W - DATA_W);
    int half = 1 << (DATA_W - 1);
    int u = int'(ptop % half);
    bit hi = (ptop >= half);
    int idx;
    real ang;
    case (wave)
      0: return hi ? -(half - 1) : (half - 1);
      1: return int'(ptop) - half;
`ifdef DDFS_SINE_LUT_EN
      3: begin
        idx = int'(p >> (PHASE_W - LUT_AW));
        ang = 2.0 * 3.141592653589793 * idx / (2.0 ** LUT_AW);
        return int'((half - 1) * $sin(ang));
      end
`endif
      default: return hi ? (half - 1) - 2 * u : -half + 2 * u;
    endcase
  endfunction

  // One accepted tick: every enabled channel uses its pre-step phase, then steps.
  function automatic int model_frame();
    int sum = 0;
    longint p;
    for (int i = 0; i < N_CH; i++) begin
      if (m_en[i] != 0) begin
        p = (m_phase[i] + m_pcw[i]) & PMASK;
        sum += (wave_val(m_wave[i], p) * m_amp[i]) >>> AMP_W;
        m_phase[i] = (m_phase[i] + m_fcw[i]) & PMASK;
      end else begin
        m_phase[i] = 0;
      end
    end
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    return sum;
  endfunction

  task automatic do_write(input int ch, input int r, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = 4'(ch * 4 + r); wr_data = d;
    @(negedge clk);
    wr = 1'b0;
    case (r)
      0: m_fcw[ch] = longint'(d) & PMASK;
      1: m_pcw[ch] = longint'(d) & PMASK;
      2: begin
        m_en[ch] = int'(d[0]); m_wave[ch] = int'(d[2:1]); m_amp[ch] = int'(d[10:3]);
        if (!d[0]) m_phase[ch] = 0;
      end
      default: if (ch == 0) m_ovr = 0;
    endcase
  endtask

  task automatic read_check(input string tag, input int ch, input int r, input logic [31:0] exp);
    @(negedge clk);
    addr = 4'(ch * 4 + r);
    #1 check(tag, rd_data, exp);
  endtask

  function automatic logic [31:0] ctrl_word(int en, int wave, int amp);
    return 32'((amp << 3) | (wave << 1) | en);
  endfunction

  // Tick at step 0, optional extra tick at step 'second'; expects exactly one valid pulse.
  task automatic run_frame(input string tag, input int second);
    int exp, first, pulses;
    logic [15:0] got;
    first = -1; pulses = 0; got = '0;
    exp = model_frame();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (dout_valid) begin
        pulses++;
        if (first < 0) begin first = i; got = dout; end
      end
      if (i == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      sample_tick = (i == 0) || (i == second);
      if (i == second && m_ovr < 255) m_ovr++;
    end
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, ".pulses"}, 32'(pulses), 32'd1);
    check({tag, ".latency"}, 32'(first - 1), 32'(N_CH + 4));
    check({tag, ".dout"}, {{16{got[15]}}, got}, 32'(exp));
    last_dout = got;
    $display("frame %s dout=%0d expected=%0d latency=%0d pulses=%0d", tag, $signed(got), exp, first - 1, pulses);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    model_clear();
    last_dout = '0;

    // Reset and idle
    idle(3);
    reset = 1'b0;
    idle(10);
    check("rst.dout", 32'(dout), 32'd0);
    check("rst.valid", 32'(dout_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    read_check("rst.reg3", 0, 3, 32'd0);

    // Channel 0 sawtooth, ticks every 64 cycles
    do_write(0, 0, 32'h0400_0000);
    do_write(0, 2, ctrl_word(1, 1, 255));
    read_check("rd.fcw0", 0, 0, 32'h0400_0000);
    read_check("rd.ctrl0", 0, 2, ctrl_word(1, 1, 255));
    run_frame("saw0", -1);
    check("saw0.lit", {{16{last_dout[15]}}, last_dout}, 32'(-32640));
    idle(39);
    run_frame("saw1", -1);
    check("saw1.lit", {{16{last_dout[15]}}, last_dout}, 32'(-28560));

    // Four squares at full scale, then shifted half a period
    for (int c = 0; c < N_CH; c++) do_write(c, 2, ctrl_word(0, 0, 0));
    for (int c = 0; c < N_CH; c++) begin
      do_write(c, 0, 32'd0);
      do_write(c, 1, 32'd0);
      do_write(c, 2, ctrl_word(1, 0, 255));
    end
    run_frame("sqpos", -1);
    check("sqpos.lit", {{16{last_dout[15]}}, last_dout}, 32'd32767);
    for (int c = 0; c < N_CH; c++) do_write(c, 1, 32'h2000_0000);
    run_frame("sqneg", -1);
    check("sqneg.lit", {{16{last_dout[15]}}, last_dout}, 32'(-32768));

    // Overrun: second tick two cycles into the frame
    run_frame("ovr", 2);
    read_check("ovr.reg3", 0, 3, 32'(m_ovr));
    read_check("ovr.reg3lit", 0, 3, 32'h001);
    do_write(0, 3, 32'd0);
    read_check("ovr.clr", 0, 3, 32'd0);

    // Disable restarts phase
    for (int c = 0; c < N_CH; c++) do_write(c, 2, ctrl_word(0, 0, 0));
    for (int c = 0; c < N_CH; c++) do_write(c, 1, 32'd0);
    do_write(0, 0, 32'h0400_0000);
    do_write(0, 2, ctrl_word(1, 1, 255));
    for (int f = 0; f < 3; f++) run_frame($sformatf("run%0d", f), -1);
    do_write(0, 2, ctrl_word(0, 1, 255));
    do_write(0, 2, ctrl_word(1, 1, 255));
    run_frame("restart", -1);
    check("restart.lit", {{16{last_dout[15]}}, last_dout}, 32'(-32640));

    // Wave 3 at a quarter period
    do_write(0, 2, ctrl_word(0, 3, 255));
    do_write(0, 2, ctrl_word(1, 3, 255));
    for (int f = 0; f < 5; f++) run_frame($sformatf("w3f%0d", f), -1);
`ifdef DDFS_SINE_LUT_EN
    check("w3f4.lit", {{16{last_dout[15]}}, last_dout}, 32'd32639);
`else
    check("w3f4.lit", {{16{last_dout[15]}}, last_dout}, 32'd0);
`endif

    // Randomized settings
    for (int cfg = 0; cfg < 4; cfg++) begin
      for (int c = 0; c < N_CH; c++) begin
        do_write(c, 0, $urandom);
        do_write(c, 1, $urandom);
        do_write(c, 2, ctrl_word(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 3), $urandom_range(0, 255)));
      end
      for (int f = 0; f < 3; f++) run_frame($sformatf("rnd%0d_%0d", cfg, f), -1);
    end

    // Reset in the middle of a frame
    @(negedge clk); sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (dout_valid) pulses++;
    end
    check("abort.pulses", 32'(pulses), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.dout", 32'(dout), 32'd0);
    read_check("abort.fcw0", 0, 0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
